// File: rtl/ibex_instr_mem_responder.sv
// Instruction-fetch responder: req/gnt/rvalid front end over a word-wide SRAM,
// with an outstanding-request limit, stall injection and a fixed-latency in-order return pipe.
module ibex_instr_mem_responder #(
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
   parameter int unsigned ADDR_WIDTH  = 10,
   parameter int unsigned RD_LATENCY  = 1,
   parameter int unsigned OUTSTANDING = 2,
   parameter logic [31:0] ERR_RDATA   = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        instr_req_i,
   input  logic [31:0] instr_addr_i,
   output logic        instr_gnt_o,
   output logic        instr_rvalid_o,
   output logic [31:0] instr_rdata_o,
   input  logic        stall_i,
   input  logic        load_we_i,
   input  logic [31:0] load_addr_i,
   input  logic [31:0] load_wdata_i
);

   localparam int unsigned DEPTH     = 2 ** ADDR_WIDTH;
   localparam logic [29:0] BASE_WORD = BASE_ADDR[31:2];
   localparam logic [30:0] DEPTH_W   = 31'(DEPTH);
   localparam logic [2:0]  OUT_LIM   = 3'(OUTSTANDING);

   logic [31:0]           mem [DEPTH];
   logic [31:0]           rd_word_q;
   logic [31:0]           hold_q;
   logic [2:0]            cnt_q;
   logic [29:0]           fetch_off;
   logic [29:0]           load_off;
   logic                  fetch_in_range;
   logic                  load_in_range;
   logic [ADDR_WIDTH-1:0] fetch_idx;
   logic [ADDR_WIDTH-1:0] load_idx;
   logic                  retire;
   logic                  stage_valid [RD_LATENCY];
   logic [31:0]           stage_data  [RD_LATENCY];
   logic                  unused_addr_bits;

   assign unused_addr_bits = ^{instr_addr_i[1:0], load_addr_i[1:0]};

   assign fetch_off      = instr_addr_i[31:2] - BASE_WORD;
   assign load_off       = load_addr_i[31:2] - BASE_WORD;
   assign fetch_in_range = {1'b0, fetch_off} < DEPTH_W;
   assign load_in_range  = {1'b0, load_off} < DEPTH_W;
   assign fetch_idx      = instr_addr_i[ADDR_WIDTH+1:2];
   assign load_idx       = load_addr_i[ADDR_WIDTH+1:2];

   // A slot retiring this cycle can be handed straight to a new request.
   assign retire      = stage_valid[RD_LATENCY-1];
   assign instr_gnt_o = instr_req_i & ~stall_i & ((cnt_q - {2'b0, retire}) < OUT_LIM);

   // Read-first RAM: the read register samples the old word when a load hits the same index.
   always_ff @(posedge clk) begin
      if (load_we_i && load_in_range) begin
         mem[load_idx] <= load_wdata_i;
      end
      if (instr_gnt_o) begin
         rd_word_q <= mem[fetch_idx];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= 3'd0;
      end else begin
         cnt_q <= cnt_q + {2'b0, instr_gnt_o} - {2'b0, retire};
      end
   end

   generate
      for (genvar gi = 0; gi < RD_LATENCY; gi++) begin : g_stage
         if (gi == 0) begin : g_head
            logic valid_q;
            logic range_q;
            always_ff @(posedge clk or negedge rst_n) begin
               if (!rst_n) begin
                  valid_q <= 1'b0;
                  range_q <= 1'b0;
               end else begin
                  valid_q <= instr_gnt_o;
                  range_q <= fetch_in_range;
               end
            end
            assign stage_valid[gi] = valid_q;
            assign stage_data[gi]  = range_q ? rd_word_q : ERR_RDATA;
         end else begin : g_tail
            logic        valid_q;
            logic [31:0] data_q;
            always_ff @(posedge clk or negedge rst_n) begin
               if (!rst_n) begin
                  valid_q <= 1'b0;
                  data_q  <= 32'h0;
               end else begin
                  valid_q <= stage_valid[gi-1];
                  data_q  <= stage_data[gi-1];
               end
            end
            assign stage_valid[gi] = valid_q;
            assign stage_data[gi]  = data_q;
         end
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_q <= 32'h0;
      end else if (retire) begin
         hold_q <= stage_data[RD_LATENCY-1];
      end
   end

   assign instr_rvalid_o = retire;
   assign instr_rdata_o  = retire ? stage_data[RD_LATENCY-1] : hold_q;

   // Initiator obligations; violations are flagged, not repaired.
   a_addr_stable: assert property (@(posedge clk) disable iff (!rst_n)
      (instr_req_i && !instr_gnt_o) |=> (!instr_req_i || $stable(instr_addr_i)));
   a_cnt_limit: assert property (@(posedge clk) disable iff (!rst_n) cnt_q <= OUT_LIM);

endmodule

// File: tb/tb_ibex_instr_mem_responder.sv
// Directed bench for ibex_instr_mem_responder: a reference model predicts grant, rvalid and
// in-flight count each cycle; expected read data is queued at grant and popped at rvalid.
module tb_ibex_instr_mem_responder;

   localparam int LAT = 3;
   localparam int OUT = 2;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        instr_req_i = 1'b0;
   logic [31:0] instr_addr_i = 32'h0;
   logic        instr_gnt_o;
   logic        instr_rvalid_o;
   logic [31:0] instr_rdata_o;
   logic        stall_i = 1'b0;
   logic        load_we_i = 1'b0;
   logic [31:0] load_addr_i = 32'h0;
   logic [31:0] load_wdata_i = 32'h0;

   int          vectors = 0;
   int          errors = 0;
   logic [31:0] mem_m [16];
   logic [31:0] exp_q [$];
   logic [LAT-1:0] hist = '0;
   logic [31:0] last_rdata = 32'h0;
   logic        last_gnt = 1'b0;

   ibex_instr_mem_responder #(
      .BASE_ADDR  (32'h0000_1000),
      .ADDR_WIDTH (4),
      .RD_LATENCY (LAT),
      .OUTSTANDING(OUT),
      .ERR_RDATA  (32'h0000_0000)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .instr_req_i   (instr_req_i),
      .instr_addr_i  (instr_addr_i),
      .instr_gnt_o   (instr_gnt_o),
      .instr_rvalid_o(instr_rvalid_o),
      .instr_rdata_o (instr_rdata_o),
      .stall_i       (stall_i),
      .load_we_i     (load_we_i),
      .load_addr_i   (load_addr_i),
      .load_wdata_i  (load_wdata_i)
   );

   always #5 clk = ~clk;

   function automatic bit in_range(input logic [31:0] a);
      logic [29:0] off;
      off = a[31:2] - 30'h400;
      return off < 30'd16;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One clock cycle: check outputs at the falling edge, then advance the model at the rising edge.
   task automatic step();
      int   cnt;
      logic exp_rv;
      logic exp_gnt;
      logic [31:0] d;
      @(negedge clk);
      cnt     = $countones(hist);
      exp_rv  = hist[LAT-1];
      exp_gnt = instr_req_i & ~stall_i & ((cnt - int'(exp_rv)) < OUT);
      last_gnt = instr_gnt_o;
      chk("gnt", {31'b0, instr_gnt_o}, {31'b0, exp_gnt});
      chk("rvalid", {31'b0, instr_rvalid_o}, {31'b0, exp_rv});
      chk("cnt_q", {29'b0, dut.cnt_q}, 32'(cnt));
      if (exp_gnt) exp_q.push_back(in_range(instr_addr_i) ? mem_m[instr_addr_i[5:2]] : 32'h0);
      if (exp_rv) begin
         if (exp_q.size() == 0) begin
            chk("scoreboard_empty", 32'h1, 32'h0);
         end else begin
            d = exp_q.pop_front();
            chk("rdata", instr_rdata_o, d);
            last_rdata = d;
         end
      end else begin
         chk("rdata_hold", instr_rdata_o, last_rdata);
      end
      @(posedge clk);
      if (load_we_i && in_range(load_addr_i)) mem_m[load_addr_i[5:2]] = load_wdata_i;
      if (rst_n) hist = {hist[LAT-2:0], exp_gnt};
      else hist = '0;
      #1;
   endtask

   task automatic assert_reset();
      rst_n = 1'b0;
      hist = '0;
      exp_q.delete();
      last_rdata = 32'h0;
   endtask

   task automatic load(input logic [31:0] a, input logic [31:0] d);
      load_we_i = 1'b1;
      load_addr_i = a;
      load_wdata_i = d;
      step();
      load_we_i = 1'b0;
   endtask

   task automatic fetch(input logic [31:0] a);
      instr_req_i = 1'b1;
      instr_addr_i = a;
      step();
      for (int t = 0; t < 10 && !last_gnt; t++) step();
      if (!last_gnt) chk("fetch_timeout", 32'h0, 32'h1);
      instr_req_i = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) step();
   endtask

   initial begin
      for (int i = 0; i < 16; i++) mem_m[i] = 32'h0;
      assert_reset();
      idle(3);
      rst_n = 1'b1;
      idle(1);

      // Fill the whole memory so no read returns X.
      for (int i = 0; i < 16; i++) begin
         load(32'h1000 + 32'(i * 4), (i == 0) ? 32'h0000_0013 :
                                     (i == 1) ? 32'h0010_0093 : 32'h0A00_0000 + 32'(i * 32'h111));
      end

      // Back-to-back fetches
      fetch(32'h1000);
      fetch(32'h1004);
      idle(5);

      // Request held continuously against the outstanding limit
      instr_req_i = 1'b1;
      instr_addr_i = 32'h1000;
      for (int k = 0; k < 12; k++) begin
         step();
         if (last_gnt) instr_addr_i = instr_addr_i + 32'h4;
      end
      instr_req_i = 1'b0;
      idle(5);

      // Wait states
      stall_i = 1'b1;
      instr_req_i = 1'b1;
      instr_addr_i = 32'h1008;
      idle(3);
      stall_i = 1'b0;
      fetch(32'h1008);
      idle(5);

      // Out-of-range fetches and a dropped load
      fetch(32'h1040);
      fetch(32'h0FFC);
      load(32'h0FFC, 32'hDEAD_BEEF);
      fetch(32'h1000);
      idle(5);

      // Read/write collision on the same word
      load(32'h1020, 32'hAAAA_AAAA);
      instr_req_i = 1'b1;
      instr_addr_i = 32'h1020;
      load_we_i = 1'b1;
      load_addr_i = 32'h1020;
      load_wdata_i = 32'h5555_5555;
      step();
      instr_req_i = 1'b0;
      load_we_i = 1'b0;
      fetch(32'h1020);
      idle(5);

      // Reset while a response is in flight
      fetch(32'h1004);
      assert_reset();
      idle(4);
      rst_n = 1'b1;
      idle(1);
      fetch(32'h1004);
      fetch(32'h1040);
      idle(5);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule

// File: doc/ibex_instr_mem_responder.md
# ibex_instr_mem_responder

Responder end of the core's instruction-fetch bus (req/gnt/rvalid). Sits outside the core, where the instruction SRAM lives in system and test builds. Accepts fetch requests from the IF stage's prefetch buffer and grants them subject to an outstanding-transaction limit and an injected wait-state input. Returns read data in order after a fixed, parameterised latency. Contents are loaded through a separate single-cycle write port.

## Interface
Parameters:
- BASE_ADDR, 32'h0000_0000: byte address of word 0; must be aligned to the memory size.
- ADDR_WIDTH, 10: word-address bits; memory holds 2**ADDR_WIDTH 32-bit words.
- RD_LATENCY, 1: cycles from grant to rvalid; legal range 1..4.
- OUTSTANDING, 2: maximum granted-but-not-returned requests; legal range 1..4.
- ERR_RDATA, 32'h0000_0000: data returned for out-of-range addresses; decodes as an illegal instruction.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- instr_req_i  in  1  fetch request.
- instr_addr_i  in  32  fetch byte address; bits [1:0] are ignored.
- instr_gnt_o  out  1  request accepted this cycle.
- instr_rvalid_o  out  1  instr_rdata_o is valid this cycle.
- instr_rdata_o  out  32  read data.
- stall_i  in  1  wait-state injection; suppresses grant while high.
- load_we_i  in  1  memory write strobe.
- load_addr_i  in  32  write byte address; bits [1:0] are ignored.
- load_wdata_i  in  32  write data, full word.

## Operation
- Address decode: a request is in range iff instr_addr_i[31:2] - BASE_ADDR[31:2] < 2**ADDR_WIDTH. The word index is instr_addr_i[ADDR_WIDTH+1:2]. Load decode is identical. Out-of-range loads are dropped.
- Grant (combinational): instr_gnt_o = instr_req_i & ~stall_i & (cnt_q - retire < OUTSTANDING).
  - retire = instr_rvalid_o.
  - A slot freed in the same cycle is reusable, so full throughput is one grant per cycle when OUTSTANDING >= RD_LATENCY.
- Outstanding counter cnt_q, 3 bits:
  - +1 on grant; -1 on retire; unchanged when both occur.
  - Never exceeds OUTSTANDING.
- Return pipeline: RD_LATENCY stages, each holding a valid bit, a data word and an in-range flag.
  - Stage 1 captures the memory read (or ERR_RDATA when out of range) on the grant edge.
  - Entries shift one stage per cycle, never stall, and stay in order.
- Memory read is read-first: a load to the same word in the grant cycle returns the old data. The load is visible to grants in the following cycle onward.
- Protocol the initiator is held to (assertions, not corrected):
  - instr_addr_i is stable while instr_req_i is high and instr_gnt_o is low.
  - rvalid has no backpressure.
- Memory contents are not reset. Reads of unwritten words are X in simulation.

## Timing
- Reset values: instr_rvalid_o=0, instr_rdata_o=0, cnt_q=0, all pipeline valids 0. instr_gnt_o follows its equation, so it is 0 unless a request is pending.
- Grant in cycle N gives instr_rvalid_o=1 in cycle N+RD_LATENCY, with data. instr_rdata_o holds its last value when rvalid=0.
- Grant and retire are single-cycle pulses with no minimum spacing.
- stall_i high: no grant. Requests already granted still return on schedule.
- Counter full (cnt_q=OUTSTANDING, no retire this cycle): gnt=0 until the next rvalid cycle.
- Reset asserted mid-operation: all in-flight responses are discarded and no rvalid follows. After release, the first grant behaves as from idle.
- Request deasserted after grant: the response is still delivered.

## Test plan
- Back-to-back: load 0x00000013 @0x0, 0x00100093 @0x4; RD_LATENCY=1, OUTSTANDING=2; req both on consecutive cycles -> gnt in cycles 0,1; rvalid in 1,2 with 0x00000013 then 0x00100093.
- Outstanding limit: RD_LATENCY=3, OUTSTANDING=2, req held continuously -> gnt pattern 1,1,0,1,1,0…; cnt_q never exceeds 2; data stays in order.
- Wait states: stall_i high for 3 cycles with req high at 0x8 -> gnt=0 for 3 cycles, gnt on the 4th cycle, rvalid RD_LATENCY later with the word at 0x8.
- Out of range: BASE_ADDR=0x1000, ADDR_WIDTH=4; req 0x1040 -> rvalid with 0x00000000. Load to 0x0FFC is ignored; a readback of 0x1000 is unchanged.
- Read/write collision: word 0x20 = 0xAAAAAAAA; same cycle, grant at 0x20 and load 0x55555555 -> first rvalid returns 0xAAAAAAAA, next fetch returns 0x55555555.
- Reset mid-flight: RD_LATENCY=2; grant, then assert rst_n=0 the next cycle -> no rvalid, rdata=0, cnt_q=0; after release a fresh fetch works normally.
